// File: rtl/machine_d_fsm.sv
// Moore detector for the serial pattern 1011 (overlapping matches allowed).
// The state register and the detect flag are both driven straight from flops.
module machine_d_fsm (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       x,
    output logic       F,
    output logic [2:0] S
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    logic [2:0] state_q;
    logic       f_q;

    // State register and detect flag; F is registered alongside the state it decodes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S0;
            f_q     <= 1'b0;
        end else begin
            case (state_q)
                S0: begin
                    state_q <= x ? S1 : S0;
                    f_q     <= 1'b0;
                end
                S1: begin
                    state_q <= x ? S1 : S2;
                    f_q     <= 1'b0;
                end
                S2: begin
                    state_q <= x ? S3 : S0;
                    f_q     <= 1'b0;
                end
                S3: begin
                    state_q <= x ? S4 : S2;
                    f_q     <= x;
                end
                // Trailing 1 of a completed match is reused as the first 1 of the next.
                S4: begin
                    state_q <= x ? S1 : S2;
                    f_q     <= 1'b0;
                end
                default: begin
                    state_q <= S0;
                    f_q     <= 1'b0;
                end
            endcase
        end
    end

    assign S = state_q;
    assign F = f_q;

endmodule

// File: tb/tb_machine_d_fsm.sv
// Directed bench for machine_d_fsm; expected {F,S} values are hand-computed.
module tb_machine_d_fsm;

    logic       CLK;
    logic       RESET;
    logic       x;
    logic       F;
    logic [2:0] S;

    int n_checks;
    int n_bad;

    machine_d_fsm dut (
        .CLK   (CLK),
        .RESET (RESET),
        .x     (x),
        .F     (F),
        .S     (S)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got {F,S}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic xv, input logic rv, input logic [3:0] exp);
        @(negedge CLK);
        x     = xv;
        RESET = rv;
        @(posedge CLK);
        #1;
        check_val(tag, {F, S}, exp);
    endtask

    // Plant an unused state code, then confirm it returns to S0 on the next edge.
    task automatic illegal(input logic [2:0] code, input logic xv);
        @(negedge CLK);
        RESET = 1'b0;
        x     = xv;
        force dut.state_q = code;
        #1;
        release dut.state_q;
        #1;
        check_val("illegal_hold", {F, S}, {1'b0, code});
        @(posedge CLK);
        #1;
        check_val("illegal_exit", {F, S}, 4'b0000);
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        RESET    = 1'b1;
        x        = 1'b0;

        // Reset held over several edges while x toggles.
        step("rst0", 1'b1, 1'b1, 4'b0000);
        step("rst1", 1'b0, 1'b1, 4'b0000);
        step("rst2", 1'b1, 1'b1, 4'b0000);

        // Basic detect: 0,0,1,0,1,1,0
        step("basic0", 1'b0, 1'b0, 4'b0000);
        step("basic1", 1'b0, 1'b0, 4'b0000);
        step("basic2", 1'b1, 1'b0, 4'b0001);
        step("basic3", 1'b0, 1'b0, 4'b0010);
        step("basic4", 1'b1, 1'b0, 4'b0011);
        step("basic5", 1'b1, 1'b0, 4'b1100);
        step("basic6", 1'b0, 1'b0, 4'b0010);

        // Overlap: 1,0,1,1,0,1,1 gives two detects.
        step("ov_rst", 1'b1, 1'b1, 4'b0000);
        step("ov0", 1'b1, 1'b0, 4'b0001);
        step("ov1", 1'b0, 1'b0, 4'b0010);
        step("ov2", 1'b1, 1'b0, 4'b0011);
        step("ov3", 1'b1, 1'b0, 4'b1100);
        step("ov4", 1'b0, 1'b0, 4'b0010);
        step("ov5", 1'b1, 1'b0, 4'b0011);
        step("ov6", 1'b1, 1'b0, 4'b1100);

        // Reset taking priority while in the detect state.
        step("rst_s4", 1'b1, 1'b1, 4'b0000);

        // Long run of ones: 1,0,1,1,1,1
        step("ones0", 1'b1, 1'b0, 4'b0001);
        step("ones1", 1'b0, 1'b0, 4'b0010);
        step("ones2", 1'b1, 1'b0, 4'b0011);
        step("ones3", 1'b1, 1'b0, 4'b1100);
        step("ones4", 1'b1, 1'b0, 4'b0001);
        step("ones5", 1'b1, 1'b0, 4'b0001);

        // Mid-sequence reset discards the partial match.
        step("mid_rst", 1'b0, 1'b1, 4'b0000);
        step("mid0", 1'b1, 1'b0, 4'b0001);
        step("mid1", 1'b0, 1'b0, 4'b0010);
        step("mid2", 1'b1, 1'b0, 4'b0011);
        step("mid_rst1", 1'b1, 1'b1, 4'b0000);
        step("mid3", 1'b1, 1'b0, 4'b0001);
        step("mid4", 1'b0, 1'b0, 4'b0010);
        step("mid5", 1'b1, 1'b0, 4'b0011);
        step("mid6", 1'b1, 1'b0, 4'b1100);
        step("mid7", 1'b0, 1'b0, 4'b0010);

        // Unused codes, both values of x, from S0 so that F starts low.
        step("pre_ill", 1'b0, 1'b1, 4'b0000);
        for (int c = 5; c < 8; c++) begin
            illegal(c[2:0], 1'b0);
            illegal(c[2:0], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
